fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Downstream consumer of the FIFO output port. Drains words from the FIFO with the valid/yumi protocol and packs PACK_N consecutive words into one wide beat.
- Presents each packed beat to the next stage over a valid/ready handshake.
- A flush input emits a partially filled group, tagged with a slot mask.

Parameters:
- PACK_N, 4, words per packed beat; legal range is 2 or greater.
- CNT_W, 16, width of the emitted-group counter.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- valid_i, input, 1, FIFO output data_o is valid (driven by the FIFO's valid_o).
- data_i, input, word_t, FIFO output word.
- yumi_o, output, 1, word consumed this cycle (drives the FIFO's yumi).
- flush_i, input, 1, close the current partial group.
- valid_o, output, 1, packed beat available.
- ready_i, input, 1, downstream accepts the beat.
- data_o, output, PACK_N*W, packed beat. W = $bits(word_t). Slot k occupies data_o[k*W +: W].
- mask_o, output, PACK_N, bit k is set when slot k holds a valid word.
- groups_o, output, CNT_W, count of completed output handshakes.

Behaviour:
- Reset: while reset is high, at the next edge:
  - state = FILL, idx = 0.
  - valid_o = 0, data_o = 0, mask_o = 0, groups_o = 0.
  - yumi_o is forced 0 while reset is high.
- Reset mid-group or mid-hold discards all buffered words. No beat is emitted.
- States are FILL (accumulating) and HOLD (beat presented).
- can_accept = (state == FILL) | (state == HOLD & ready_i).
- yumi_o = valid_i & can_accept & ~reset. It is combinational; there is no yumi without valid.
- Accept in FILL:
  - Write data_i to slot idx and set mask bit idx.
  - If idx == PACK_N-1: go to HOLD and set idx to 0. valid_o rises on the edge of the final yumi, so valid_o is high the cycle after it.
  - Otherwise: idx increments.
- HOLD:
  - valid_o = 1. data_o and mask_o stay stable until valid_o & ready_i.
  - On handshake without an accept: go to FILL, clear data_o and mask_o, and increment groups_o (wraps modulo 2^CNT_W).
  - On handshake together with an accept (back-to-back): the new word goes to slot 0, the buffer and mask are reset to only that slot, state = FILL, idx = 1, and groups_o increments.
- Flush in FILL:
  - If idx > 0, or an accept occurs the same cycle: go to HOLD with the current mask. An accept in that cycle is included before closing.
  - Unused slots read as zero.
  - Flush with idx == 0 and no accept is ignored.
- Flush in HOLD is ignored.
- When the accept in FILL hits idx == PACK_N-1 while flush_i is high, the group is closed once (a normal full group).
- Data is packed in arrival order: the first word goes to the lowest slot.
- valid_o must never drop without a handshake, except on reset.

Decomposition:
- Add a packer_state_e enum {FILL, HOLD} to fifo_types_pkg, next to word_t.
- Add the localparam WORD_W = $bits(word_t) to the same package.
- Single module; no sub-module is warranted.

Test Plan:
- Reset with valid_i=1 -> yumi_o=0, valid_o=0, data_o=0, mask_o=0, groups_o=0 on the first cycle after reset.
- Words 0x11,0x22,0x33,0x44 on consecutive cycles, ready_i=0 -> valid_o=1 the cycle after 0x44. data_o = {0x44,0x33,0x22,0x11} (slot 3..0), mask_o = 4'b1111. yumi_o stays 0 while HOLD with ready_i=0.
- HOLD, ready_i=1, valid_i=1, data_i=0x55 -> yumi_o=1 and groups_o becomes 1. Next cycle: state FILL, idx=1, mask_o=0001, slot 0 = 0x55.
- Words 0xA1,0xA2, then flush_i with no valid -> valid_o=1, data_o = {0,0,0xA2,0xA1}, mask_o = 0011.
- flush_i with idx=0 and valid_i=0 -> no valid_o. Flush with idx=3 plus an accept of 0xB4 -> one full group with mask 1111 and no empty beat.
- Reset asserted mid-group after 2 words -> valid_o stays 0. The next 4 words form a clean group starting at slot 0.
- Drive 2^CNT_W handshakes (CNT_W=4 override) -> groups_o wraps to 0.

Source files
------------

// File: rtl/fifo_types_pkg.sv
// Shared FIFO types: the word carried through the FIFO and the packer states.
package fifo_types_pkg;

  typedef logic [7:0] word_t;

  localparam int WORD_W = $bits(word_t);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

endpackage

// File: rtl/fifo_word_packer.sv
// Drains a FIFO with valid/yumi and packs PACK_N consecutive words into one
// wide beat, presented downstream with valid/ready. A flush closes a partial
// group early; mask_o marks which slots hold real words.
//
// Handshakes: upstream, a word moves when valid_i & yumi_o (yumi_o only
// asserts with valid_i). Downstream, a beat moves when valid_o & ready_i;
// once valid_o is high, data_o/mask_o are held until that handshake.
module fifo_word_packer
  import fifo_types_pkg::*;
#(
  parameter int PACK_N = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_i,
  input  word_t                       data_i,
  output logic                        yumi_o,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [PACK_N*WORD_W-1:0]    data_o,
  output logic [PACK_N-1:0]           mask_o,
  output logic [CNT_W-1:0]            groups_o,
  output packer_state_e               dbg_state_o,
  output logic [$clog2(PACK_N)-1:0]   dbg_idx_o
);

  localparam int IDX_W = $clog2(PACK_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_N - 1);

  packer_state_e               state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [PACK_N*WORD_W-1:0]    data_q;
  logic [PACK_N-1:0]           mask_q;
  logic [CNT_W-1:0]            groups_q;
  logic                        can_accept;

  // In HOLD a new word may only be taken when the held beat leaves this cycle.
  assign can_accept = (state_q == FILL) | ((state_q == HOLD) & ready_i);
  assign yumi_o     = valid_i & can_accept & ~reset;

  // Packer FSM: slot filling, group closing, beat release and group counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      idx_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      groups_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (yumi_o) begin
            for (int k = 0; k < PACK_N; k++) begin
              if (int'(idx_q) == k) begin
                data_q[k*WORD_W +: WORD_W] <= data_i;
                mask_q[k]                  <= 1'b1;
              end
            end
            // A flush on the final word still closes just one full group.
            if (idx_q == LAST_IDX || flush_i) begin
              state_q <= HOLD;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (flush_i && idx_q != '0) begin
            state_q <= HOLD;
            idx_q   <= '0;
          end
        end
        HOLD: begin
          if (ready_i) begin
            groups_q <= groups_q + 1'b1;
            state_q  <= FILL;
            if (yumi_o) begin
              // Back-to-back: the incoming word starts the next group in slot 0.
              data_q <= {{((PACK_N-1)*WORD_W){1'b0}}, data_i};
              mask_q <= PACK_N'(1);
              idx_q  <= IDX_W'(1);
            end else begin
              data_q <= '0;
              mask_q <= '0;
              idx_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= FILL;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign valid_o     = (state_q == HOLD);
  assign data_o      = data_q;
  assign mask_o      = mask_q;
  assign groups_o    = groups_q;
  assign dbg_state_o = state_q;
  assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (PACK_N=4, byte words, CNT_W=4 so the
// group counter wrap is reachable quickly).
module tb_fifo_word_packer;
  import fifo_types_pkg::*;

  localparam int PACK_N = 4;
  localparam int CNT_W  = 4;
  localparam int DW     = PACK_N * WORD_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               valid_i = 1'b0;
  word_t              data_i = '0;
  logic               yumi_o;
  logic               flush_i = 1'b0;
  logic               valid_o;
  logic               ready_i = 1'b0;
  logic [DW-1:0]      data_o;
  logic [PACK_N-1:0]  mask_o;
  logic [CNT_W-1:0]   groups_o;
  packer_state_e      dbg_state_o;
  logic [1:0]         dbg_idx_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic             yumi_seen;
  logic [CNT_W-1:0] exp_groups;
  logic [DW-1:0]    exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  fifo_word_packer #(.PACK_N(PACK_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
    .yumi_o(yumi_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .mask_o(mask_o), .groups_o(groups_o),
    .dbg_state_o(dbg_state_o), .dbg_idx_o(dbg_idx_o)
  );

  // driver: apply inputs at negedge, capture yumi before the edge, return 1 after it
  task automatic drive(input logic rst, input logic v, input word_t d,
                       input logic f, input logic r);
    @(negedge clk);
    reset = rst; valid_i = v; data_i = d; flush_i = f; ready_i = r;
    #1 yumi_seen = yumi_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    vec_cnt++; if (yumi_seen !== 1'b0) begin err_cnt++; $display("FAIL reset_yumi got %b want 0", yumi_seen); end
    vec_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b want 0", valid_o); end
    vec_cnt++; if (data_o !== '0) begin err_cnt++; $display("FAIL reset_data got %h want 0", data_o); end
    vec_cnt++; if (mask_o !== '0) begin err_cnt++; $display("FAIL reset_mask got %b want 0", mask_o); end
    vec_cnt++; if (groups_o !== '0) begin err_cnt++; $display("FAIL reset_groups got %0d want 0", groups_o); end
    vec_cnt++; if (dbg_state_o !== FILL || dbg_idx_o !== 2'd0) begin err_cnt++; $display("FAIL reset_state got %0d/%0d want FILL/0", dbg_state_o, dbg_idx_o); end
    exp_groups = '0;
  endtask

  task automatic test_full_group;
    word_t w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, w[i], 1'b0, 1'b0);
      vec_cnt++; if (yumi_seen !== 1'b1) begin err_cnt++; $display("FAIL fill_yumi[%0d] got %b want 1", i, yumi_seen); end
      if (i < 3) begin
        vec_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL fill_early_valid[%0d] got %b want 0", i, valid_o); end
      end
    end
    exp_q.push_back(32'h44332211);
    vec_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL full_valid got %b want 1", valid_o); end
    vec_cnt++; if (data_o !== exp_q[0]) begin err_cnt++; $display("FAIL full_data got %h want %h", data_o, exp_q[0]); end
    vec_cnt++; if (mask_o !== 4'b1111) begin err_cnt++; $display("FAIL full_mask got %b want 1111", mask_o); end
    // HOLD with ready low: no yumi, beat stable
    drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    vec_cnt++; if (yumi_seen !== 1'b0) begin err_cnt++; $display("FAIL hold_yumi got %b want 0", yumi_seen); end
    vec_cnt++; if (valid_o !== 1'b1 || data_o !== exp_q[0]) begin err_cnt++; $display("FAIL hold_stable got %b/%h want 1/%h", valid_o, data_o, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    exp_groups = exp_groups + 1'b1;
    vec_cnt++; if (yumi_seen !== 1'b1) begin err_cnt++; $display("FAIL b2b_yumi got %b want 1", yumi_seen); end
    vec_cnt++; if (groups_o !== exp_groups) begin err_cnt++; $display("FAIL b2b_groups got %0d want %0d", groups_o, exp_groups); end
    vec_cnt++; if (dbg_state_o !== FILL || dbg_idx_o !== 2'd1) begin err_cnt++; $display("FAIL b2b_state got %0d/%0d want FILL/1", dbg_state_o, dbg_idx_o); end
    vec_cnt++; if (mask_o !== 4'b0001 || data_o !== 32'h00000055 || valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_slot0 got %b/%h/%b want 0001/00000055/0", mask_o, data_o, valid_o); end
    // close the single-word group and release it
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vec_cnt++; if (valid_o !== 1'b1 || mask_o !== 4'b0001 || data_o !== 32'h00000055) begin err_cnt++; $display("FAIL b2b_flush got %b/%b/%h want 1/0001/00000055", valid_o, mask_o, data_o); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_groups = exp_groups + 1'b1;
    vec_cnt++; if (valid_o !== 1'b0 || groups_o !== exp_groups) begin err_cnt++; $display("FAIL b2b_release got %b/%0d want 0/%0d", valid_o, groups_o, exp_groups); end
  endtask

  task automatic test_flush_partial;
    drive(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    exp_q.push_back(32'h0000A2A1);
    vec_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL partial_valid got %b want 1", valid_o); end
    vec_cnt++; if (data_o !== exp_q[0]) begin err_cnt++; $display("FAIL partial_data got %h want %h", data_o, exp_q[0]); end
    vec_cnt++; if (mask_o !== 4'b0011) begin err_cnt++; $display("FAIL partial_mask got %b want 0011", mask_o); end
    void'(exp_q.pop_front());
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_groups = exp_groups + 1'b1;
    vec_cnt++; if (valid_o !== 1'b0 || data_o !== '0 || mask_o !== '0 || groups_o !== exp_groups) begin err_cnt++; $display("FAIL partial_release got %b/%h/%b/%0d want 0/0/0/%0d", valid_o, data_o, mask_o, groups_o, exp_groups); end
  endtask

  task automatic test_flush_boundary;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vec_cnt++; if (valid_o !== 1'b0 || dbg_state_o !== FILL) begin err_cnt++; $display("FAIL empty_flush got %b/%0d want 0/FILL", valid_o, dbg_state_o); end
    drive(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hB3, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hB4, 1'b1, 1'b0);
    vec_cnt++; if (yumi_seen !== 1'b1) begin err_cnt++; $display("FAIL last_flush_yumi got %b want 1", yumi_seen); end
    vec_cnt++; if (valid_o !== 1'b1 || mask_o !== 4'b1111 || data_o !== 32'hB4B3B2B1) begin err_cnt++; $display("FAIL last_flush_beat got %b/%b/%h want 1/1111/b4b3b2b1", valid_o, mask_o, data_o); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_groups = exp_groups + 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    vec_cnt++; if (valid_o !== 1'b0 || groups_o !== exp_groups) begin err_cnt++; $display("FAIL no_empty_beat got %b/%0d want 0/%0d", valid_o, groups_o, exp_groups); end
  endtask

  task automatic test_reset_mid_group;
    drive(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    exp_groups = '0;
    vec_cnt++; if (yumi_seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_yumi got %b want 0", yumi_seen); end
    vec_cnt++; if (valid_o !== 1'b0 || mask_o !== '0 || data_o !== '0 || groups_o !== '0) begin err_cnt++; $display("FAIL midrst_clear got %b/%b/%h/%0d want 0/0/0/0", valid_o, mask_o, data_o, groups_o); end
    drive(1'b0, 1'b1, 8'hD1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hD2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hD3, 1'b0, 1'b0);
    vec_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_early got %b want 0", valid_o); end
    drive(1'b0, 1'b1, 8'hD4, 1'b0, 1'b0);
    vec_cnt++; if (valid_o !== 1'b1 || mask_o !== 4'b1111 || data_o !== 32'hD4D3D2D1) begin err_cnt++; $display("FAIL midrst_group got %b/%b/%h want 1/1111/d4d3d2d1", valid_o, mask_o, data_o); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_groups = exp_groups + 1'b1;
    vec_cnt++; if (groups_o !== exp_groups) begin err_cnt++; $display("FAIL midrst_groups got %0d want %0d", groups_o, exp_groups); end
  endtask

  task automatic test_wrap;
    int n;
    n = 16 - int'(exp_groups);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, word_t'(i), 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      exp_groups = exp_groups + 1'b1;
      if (i == n - 2) begin
        vec_cnt++; if (groups_o !== 4'd15) begin err_cnt++; $display("FAIL wrap_pre got %0d want 15", groups_o); end
      end
    end
    vec_cnt++; if (groups_o !== 4'd0 || exp_groups !== 4'd0) begin err_cnt++; $display("FAIL wrap_zero got %0d want 0", groups_o); end
  endtask

  initial begin
    test_reset;
    test_full_group;
    test_back_to_back;
    test_flush_partial;
    test_flush_boundary;
    test_reset_mid_group;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
